// File: rtl/amp_i2c_master.sv
// I2C initiator for the amplifier configuration bus: single-register writes, plus
// register reads via repeated START when AMP_I2C_READ_EN is defined.
module amp_i2c_master #(
  parameter int DIV = 16  // clk cycles per SCL quarter-phase, must be >= 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       sda_i
);
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_ADDR_W = 4'd2;
  localparam logic [3:0] S_ACK1   = 4'd3;
  localparam logic [3:0] S_REG    = 4'd4;
  localparam logic [3:0] S_ACK2   = 4'd5;
  localparam logic [3:0] S_DATA   = 4'd6;
  localparam logic [3:0] S_ACK3   = 4'd7;
  localparam logic [3:0] S_STOP   = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;
`ifdef AMP_I2C_READ_EN
  localparam logic [3:0] S_RSTART = 4'd10;
  localparam logic [3:0] S_ADDR_R = 4'd11;
  localparam logic [3:0] S_READ   = 4'd12;
  localparam logic [3:0] S_MNACK  = 4'd13;
`endif

  logic [3:0]    state, nxt;
  logic [DW-1:0] div_cnt;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [6:0]    dev_l;
  logic [7:0]    reg_l, dat_l, tx_byte;
  logic          sda_s, byte_st, ack_st, tx_bit;
  logic          q_end, smp, slot_end;

`ifdef AMP_I2C_READ_EN
  logic       rw_l;
  logic [7:0] rx_sh;
`endif

  assign q_end    = (div_cnt == DIV_LAST);
  assign smp      = q_end && (q == 2'd2);
  assign slot_end = q_end && (q == 2'd3);
  assign tx_bit   = tx_byte[3'd7 - bit_cnt];

  // Next state is only taken at slot_end; byte_st/ack_st qualify counters and NACK.
  always_comb begin
    nxt     = state;
    byte_st = 1'b0;
    ack_st  = 1'b0;
    tx_byte = 8'hFF;
    case (state)
      S_START:  nxt = S_ADDR_W;
      S_ADDR_W: begin
        byte_st = 1'b1;
        tx_byte = {dev_l, 1'b0};
        if (bit_cnt == 3'd7) nxt = S_ACK1;
      end
      S_ACK1: begin
        ack_st = 1'b1;
        nxt    = sda_s ? S_STOP : S_REG;
      end
      S_REG: begin
        byte_st = 1'b1;
        tx_byte = reg_l;
        if (bit_cnt == 3'd7) nxt = S_ACK2;
      end
      S_ACK2: begin
        ack_st = 1'b1;
`ifdef AMP_I2C_READ_EN
        nxt    = sda_s ? S_STOP : (rw_l ? S_RSTART : S_DATA);
`else
        nxt    = sda_s ? S_STOP : S_DATA;
`endif
      end
      S_DATA: begin
        byte_st = 1'b1;
        tx_byte = dat_l;
        if (bit_cnt == 3'd7) nxt = S_ACK3;
      end
      S_ACK3: begin
        ack_st = 1'b1;
`ifdef AMP_I2C_READ_EN
        nxt    = (!sda_s && rw_l) ? S_READ : S_STOP;
`else
        nxt    = S_STOP;
`endif
      end
`ifdef AMP_I2C_READ_EN
      S_RSTART: nxt = S_ADDR_R;
      S_ADDR_R: begin
        byte_st = 1'b1;
        tx_byte = {dev_l, 1'b1};
        if (bit_cnt == 3'd7) nxt = S_ACK3;
      end
      S_READ: begin
        byte_st = 1'b1;
        if (bit_cnt == 3'd7) nxt = S_MNACK;
      end
      S_MNACK:  nxt = S_STOP;
`endif
      S_STOP:   nxt = S_DONE;
      default:  nxt = state;
    endcase
  end

  // Bus levels per quarter; data slots hold SCL low for q0/q1 and high for q2/q3.
  always_comb begin
    scl_o = 1'b1;
    sda_o = 1'b1;
    case (state)
      S_START: begin
        scl_o = (q != 2'd3);
        sda_o = ~q[1];
      end
      S_STOP: begin
        scl_o = (q != 2'd0);
        sda_o = q[1];
      end
      S_ADDR_W, S_REG, S_DATA: begin
        scl_o = q[1];
        sda_o = tx_bit;
      end
      S_ACK1, S_ACK2, S_ACK3: scl_o = q[1];
`ifdef AMP_I2C_READ_EN
      S_RSTART: begin
        scl_o = (q == 2'd1) || (q == 2'd2);
        sda_o = ~q[1];
      end
      S_ADDR_R: begin
        scl_o = q[1];
        sda_o = tx_bit;
      end
      S_READ, S_MNACK: scl_o = q[1];
`endif
      default: begin
        scl_o = 1'b1;
        sda_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      q       <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      sda_s   <= 1'b1;
      dev_l   <= '0;
      reg_l   <= '0;
      dat_l   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          dev_l   <= dev_addr;
          reg_l   <= reg_addr;
          dat_l   <= wr_data;
          busy    <= 1'b1;
          ack_err <= 1'b0;
          div_cnt <= '0;
          q       <= '0;
          bit_cnt <= '0;
          state   <= S_START;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          div_cnt <= q_end ? '0 : div_cnt + 1'b1;
          if (q_end) q <= q + 2'd1;
          if (smp) sda_s <= sda_i;
          if (slot_end) begin
            state <= nxt;
            // 3-bit counter wraps 7->0 as the byte hands over to its ACK slot
            if (byte_st) bit_cnt <= bit_cnt + 3'd1;
            if (ack_st && sda_s) ack_err <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef AMP_I2C_READ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_l    <= 1'b0;
      rx_sh   <= '0;
      rd_data <= '0;
    end else begin
      if (state == S_IDLE && start) rw_l <= rw;
      if (state == S_READ && smp) rx_sh <= {rx_sh[6:0], sda_i};
      if (state == S_DONE && rw_l && !ack_err) rd_data <= rx_sh;
    end
  end
`else
  logic unused_rw;
  assign unused_rw = rw;
  assign rd_data   = 8'h00;
`endif

endmodule

// File: tb/tb_amp_i2c_master.sv
// Bench for amp_i2c_master: responder model on the wired-AND SDA line, bus decoder,
// and a scoreboard of expected transaction results popped at each done pulse.
module tb_amp_i2c_master;
  localparam int DIV = 4;
`ifdef AMP_I2C_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0, wr_data = '0;
  logic       busy, done, ack_err, scl_o, sda_o, sda_i;
  logic [7:0] rd_data;
  logic       slv_sda = 1'b1;

  assign sda_i = sda_o & slv_sda;

  amp_i2c_master #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .ack_err(ack_err), .rd_data(rd_data), .scl_o(scl_o), .sda_o(sda_o), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] ra, wd, srd;
    int         nack_at;   // 1-based byte the responder NACKs, 0 = none
    logic       exp_err;
    logic [7:0] exp_rd;
    int         exp_lat;
  } vec_t;

  typedef struct packed {
    int              lat;
    logic            err;
    logic [7:0]      rd;
    int              nb;
    logic [3:0][7:0] b;
    logic [3:0]      a;
    int              nst;
  } exp_t;

  int checks = 0, fails = 0;
  int cyc = 0, t_acc = 0, n_done = 0, last_done = 0;
  int bitn = 0, tot = 0, bis = 0, nst = 0, nsp = 0, nack_at = 0;
  logic [7:0] byte_sh = '0, slv_rd = '0;
  logic rd_phase = 1'b0, scl_p = 1'b1, sda_p = 1'b1, busy_p = 1'b0, done_p = 1'b0;
  exp_t sb[$];
  logic [7:0] obs_b[$];
  logic       obs_a[$];
  vec_t vecs[8];

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(vec_t v);
    exp_t e;
    logic [7:0] seq[4];
    bit rdp = v.rw && RD_EN;
    e = '0;
    seq[0] = {v.dev, 1'b0};
    seq[1] = v.ra;
    seq[2] = rdp ? {v.dev, 1'b1} : v.wd;
    seq[3] = v.srd;
    e.nb = rdp ? 4 : 3;
    if (v.nack_at > 0) e.nb = v.nack_at;
    for (int i = 0; i < e.nb; i++) begin
      e.b[i] = seq[i];
      e.a[i] = (i == v.nack_at - 1) || (rdp && i == 3);
    end
    e.nst = (rdp && (v.nack_at == 0 || v.nack_at > 2)) ? 2 : 1;
    e.lat = v.exp_lat;
    e.err = v.exp_err;
    e.rd  = v.exp_rd;
    return e;
  endfunction

  task automatic check_done();
    exp_t e;
    n_done++;
    last_done = cyc;
    chk("done_pulse_prev", done_p, 0);
    chk("busy_at_done", busy, 0);
    chk("scl_idle", scl_o, 1);
    chk("sda_idle", sda_o, 1);
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
    end else begin
      e = sb.pop_front();
      chk("latency", cyc - t_acc, e.lat);
      chk("ack_err", ack_err, e.err);
      chk("rd_data", rd_data, e.rd);
      chk("nbytes", obs_b.size(), e.nb);
      for (int i = 0; i < e.nb && i < obs_b.size(); i++) begin
        chk($sformatf("byte%0d", i), obs_b[i], e.b[i]);
        chk($sformatf("ackbit%0d", i), obs_a[i], e.a[i]);
      end
      chk("starts", nst, e.nst);
      chk("stops", nsp, 1);
    end
    obs_b.delete();
    obs_a.delete();
    nst = 0;
    nsp = 0;
  endtask

  // One clk: sample on the falling edge, decode the bus, run the responder.
  task automatic tick();
    logic sl;
    @(negedge clk);
    cyc++;
    sl = sda_i;
    if (reset) begin
      bitn = 0; tot = 0; bis = 0; nst = 0; nsp = 0;
      rd_phase = 1'b0; slv_sda = 1'b1;
      obs_b.delete(); obs_a.delete(); sb.delete();
    end else begin
      if (scl_p && scl_o && sda_p && !sl) begin
        nst++; bitn = 0; bis = 0;
      end else if (scl_p && scl_o && !sda_p && sl) begin
        nsp++; bitn = 0; tot = 0; rd_phase = 1'b0;
      end else if (!scl_p && scl_o) begin
        if (bitn < 8) begin
          byte_sh = {byte_sh[6:0], sl};
          bitn++;
        end else begin
          obs_b.push_back(byte_sh);
          obs_a.push_back(sl);
          tot++; bis++; bitn = 0;
          if (rd_phase) rd_phase = 1'b0;
          else if (bis == 1 && byte_sh[0] && !sl) rd_phase = 1'b1;
        end
      end else if (scl_p && !scl_o) begin
        if (bitn == 8 && !rd_phase) slv_sda = (tot + 1 == nack_at);
        else if (rd_phase && bitn < 8) slv_sda = slv_rd[7 - bitn];
        else slv_sda = 1'b1;
      end
      if (busy && !busy_p) t_acc = cyc;
      if (done) check_done();
    end
    scl_p = scl_o; sda_p = sl; busy_p = busy; done_p = done;
  endtask

  task automatic drive(vec_t v);
    rw = v.rw; dev_addr = v.dev; reg_addr = v.ra; wr_data = v.wd;
    nack_at = v.nack_at; slv_rd = v.srd;
  endtask

  task automatic launch(vec_t v);
    drive(v);
    sb.push_back(mk(v));
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0 = n_done;
    int to = 0;
    while (n_done == d0 && to < 3000) begin
      tick();
      to++;
    end
    if (n_done == d0) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout actual=no_done expected=done", nm);
    end
  endtask

  initial begin
    int d0;
    vec_t v;
    vecs[0] = '{rw:1'b0, dev:7'h2C, ra:8'h05, wd:8'hA3, srd:8'h00, nack_at:0,
                exp_err:1'b0, exp_rd:8'h00, exp_lat:116*DIV+1};
    vecs[1] = '{rw:1'b0, dev:7'h2C, ra:8'h05, wd:8'hA3, srd:8'h00, nack_at:1,
                exp_err:1'b1, exp_rd:8'h00, exp_lat:44*DIV+1};
    vecs[2] = '{rw:1'b0, dev:7'h50, ra:8'hFF, wd:8'h00, srd:8'h00, nack_at:2,
                exp_err:1'b1, exp_rd:8'h00, exp_lat:80*DIV+1};
    vecs[3] = '{rw:1'b0, dev:7'h7F, ra:8'h80, wd:8'h01, srd:8'h00, nack_at:3,
                exp_err:1'b1, exp_rd:8'h00, exp_lat:116*DIV+1};
    vecs[4] = '{rw:1'b0, dev:7'h00, ra:8'h00, wd:8'hFF, srd:8'h00, nack_at:0,
                exp_err:1'b0, exp_rd:8'h00, exp_lat:116*DIV+1};
    vecs[5] = '{rw:1'b1, dev:7'h2C, ra:8'h10, wd:8'h3C, srd:8'h7E, nack_at:0,
                exp_err:1'b0, exp_rd:(RD_EN ? 8'h7E : 8'h00),
                exp_lat:(RD_EN ? 156*DIV+1 : 116*DIV+1)};
    vecs[6] = '{rw:1'b1, dev:7'h2C, ra:8'h11, wd:8'h5A, srd:8'h81, nack_at:3,
                exp_err:1'b1, exp_rd:(RD_EN ? 8'h7E : 8'h00),
                exp_lat:(RD_EN ? 120*DIV+1 : 116*DIV+1)};
    vecs[7] = '{rw:1'b0, dev:7'h15, ra:8'hC3, wd:8'h96, srd:8'h00, nack_at:0,
                exp_err:1'b0, exp_rd:(RD_EN ? 8'h7E : 8'h00), exp_lat:116*DIV+1};

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_scl", scl_o, 1);
    chk("rst_sda", sda_o, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i]);
      wait_done($sformatf("vec%0d", i));
      repeat (5) tick();
      chk($sformatf("vec%0d_ack_err_hold", i), ack_err, vecs[i].exp_err);
    end

    // start pulsed while busy must be ignored and must not disturb latched fields
    d0 = n_done;
    launch(vecs[0]);
    repeat (100) tick();
    rw = 1'b1; dev_addr = 7'h11; reg_addr = 8'h99; wr_data = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_ignore");
    repeat (700) tick();
    chk("busy_ignore_done_count", n_done - d0, 1);

    // reset during the DATA byte
    launch(vecs[0]);
    repeat (320) tick();
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("midrst_scl", scl_o, 1);
    chk("midrst_sda", sda_o, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ack_err", ack_err, 0);
    chk("midrst_rd_data", rd_data, 0);
    reset = 1'b0;
    repeat (5) tick();
    v = vecs[4];
    v.exp_rd = 8'h00;
    launch(v);
    wait_done("after_reset");

    // start held high: second transaction accepted in the cycle right after done
    repeat (5) tick();
    drive(vecs[0]);
    sb.push_back(mk(vecs[0]));
    sb.push_back(mk(vecs[0]));
    start = 1'b1;
    wait_done("b2b_first");
    tick();
    start = 1'b0;
    chk("b2b_accept_cycle", t_acc, last_done + 1);
    chk("b2b_busy", busy, 1);
    wait_done("b2b_second");
    repeat (20) tick();
    chk("final_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/amp_i2c_master.md
Name: amp_i2c_master

Overview:
- I2C initiator that configures the external amplifier over the amp_i2c_scl / amp_i2c_sdao / amp_i2c_sdai pins of toi2s_tt_top.
- It is the counterpart of the i2c_if responder: it issues single-register write transactions, and optionally read transactions, to a 7-bit device address.
- Command side: a start/busy/done handshake, driven by a future amplifier-init sequencer or by register-bank fields.
- SCL is generated internally by a clock divider.

Parameters:
- DIV, 16: clk cycles per SCL quarter-phase; minimum 2. SCL period = 4*DIV clk.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- start  in  1  transaction request; sampled only when busy=0
- rw  in  1  0=write, 1=read (read requires AMP_I2C_READ_EN)
- dev_addr  in  7  target device address
- reg_addr  in  8  target register address
- wr_data  in  8  write payload
- busy  out  1  transaction in progress
- done  out  1  single-cycle completion pulse
- ack_err  out  1  NACK seen in last transaction; held until next accepted start
- rd_data  out  8  last read byte
- scl_o  out  1  SCL; 1=release, 0=drive low (maps to amp_i2c_scl)
- sda_o  out  1  SDA; 1=release, 0=drive low (maps to amp_i2c_sdao)
- sda_i  in  1  SDA pin sense (maps to amp_i2c_sdai)

Behaviour:
- Reset (synchronous, active-high, one clk edge): scl_o=1, sda_o=1, busy=0, done=0, ack_err=0, rd_data=0, FSM=IDLE, divider=0.
- Reset mid-transaction releases both lines at the next edge. No STOP is generated.
- Timing base: a divider counts 0..DIV-1. Each wrap advances a quarter-phase counter q (0..3). Each bit slot is 4 quarters:
  - q0: SCL=0, SDA updated at entry.
  - q1: SCL=0.
  - q2: SCL=1.
  - q3: SCL=1; sda_i sampled on the last clk of q2.
- Accept: in IDLE with start=1 at edge N, the block latches rw/dev_addr/reg_addr/wr_data, sets busy=1, clears ack_err and the divider. Each state lasts 4 quarters.
- FSM states:
  - IDLE
  - START: SDA=1,SCL=1 for q0,q1; SDA=0,SCL=1 for q2; SDA=0,SCL=0 for q3.
  - ADDR_W: 8 bits {dev_addr,0}, MSB first.
  - ACK1: SDA released; sample.
  - REG: 8 bits reg_addr.
  - ACK2.
  - Write path: DATA (8 bits wr_data) -> ACK3 -> STOP.
  - Read path: RSTART -> ADDR_R ({dev_addr,1}) -> ACK3 -> READ (8 bits sampled into shift register, MSB first, SDA released) -> MNACK (SDA released=NACK) -> STOP.
    - RSTART: SCL=0,SDA=1 for q0; SCL=1,SDA=1 for q1; SCL=1,SDA=0 for q2; SCL=0,SDA=0 for q3.
  - STOP: SCL=0,SDA=0 for q0; SCL=1,SDA=0 for q1; SCL=1,SDA=1 for q2,q3 (bus free).
  - DONE: one clk, then IDLE.
- NACK (sda_i=1 sampled in any ACKn): set ack_err=1 and go directly to STOP. Remaining bytes are skipped.
- Completion: done=1 and busy=0 in the same cycle, the clk after STOP ends; rd_data updated that same cycle (read path only, and only without NACK).
- Write latency: start edge to done = 116*DIV+1 clk (4 START + 27 bit slots + 4 STOP, in quarter units of DIV clk).
- start while busy: ignored, no queueing.
- start held high across done: a new transaction is accepted on the IDLE cycle following DONE.
- Bit counter is 3 bits and wraps 7->0 at the byte-to-ACK transition.
- sda_o changes only while SCL is low, except in START, RSTART and STOP.

Optional Feature:
- AMP_I2C_READ_EN defined: read path (RSTART, ADDR_R, READ, MNACK) and rd_data capture are present.
- Undefined: rw is ignored and every transaction is a write; rd_data is constant 0; the read states are not synthesized.

Test Plan:
- DIV=4, write dev 0x2C reg 0x05 data 0xA3, slave model ACKs all -> SDA bytes 0x58,0x05,0xA3 seen on SCL rising edges; done exactly 465 clk after start edge; ack_err=0; lines idle high.
- Same transaction with slave NACK on the address byte -> STOP follows ACK1 immediately; done asserted; ack_err=1; no REG/DATA bits clocked.
- With AMP_I2C_READ_EN: read dev 0x2C reg 0x10, slave returns 0x7E -> repeated START seen, byte 0x59 sent, master NACK on data byte, rd_data=0x7E at done.
- Pulse start again while busy -> ignored; exactly one done pulse; latched fields unchanged.
- Assert reset mid-DATA byte -> next cycle scl_o=1, sda_o=1, busy=0, ack_err=0; new start afterwards completes normally.
- start held high continuously -> back-to-back transactions; each begins the cycle after DONE; the START condition is preceded by bus-free SCL=SDA=1.
